// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared definitions for the CPU data-memory slice.
//               Holds the clear-sequencer state encoding, the byte-lane
//               width and the byte-merge helper used for write and
//               forwarding paths.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    // Clear sequencer states
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Bits per byte lane
    localparam int c_byte_w = 8;

    // Selects the new byte when its enable is set, otherwise keeps the old one
    function automatic logic [c_byte_w-1:0] merge_byte(
        input logic [c_byte_w-1:0] old_b,
        input logic [c_byte_w-1:0] new_b,
        input logic                en
    );
        return en ? new_b : old_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_dp_be_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_dp_be_if
// Description : Bus bundle for the dual-port byte-enable SRAM.
//               master : requester (drives wr_*/rd_en/rd_addr, sees busy and
//                        read results)
//               slave  : memory (drives busy, rd_data, rd_valid)
// Ports       : busy, wr_en, wr_addr[ADDR], wr_be[WIDTH/8], wr_data[WIDTH],
//               rd_en, rd_addr[ADDR], rd_data[WIDTH], rd_valid
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_dp_be_if #(
    parameter int ADDR  = 8,
    parameter int WIDTH = 32
) ();
    logic               busy;
    logic               wr_en;
    logic [ADDR-1:0]    wr_addr;
    logic [WIDTH/8-1:0] wr_be;
    logic [WIDTH-1:0]   wr_data;
    logic               rd_en;
    logic [ADDR-1:0]    rd_addr;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_valid;

    modport master (
        input  busy, rd_data, rd_valid,
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
    );

    modport slave (
        output busy, rd_data, rd_valid,
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr
    );
endinterface
`default_nettype wire

// File: rtl/sram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sram_rd_pipe
// Description : RD_LAT-deep read-result shift register with a valid flag.
//               Data stages only load when the preceding stage is valid, so
//               the output word holds its last value between results.
// Ports       : clk, rst (sync, active-high), i_valid, i_data[WIDTH],
//               o_valid, o_data[WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_valid,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic      [WIDTH-1:0] o_data
);
    logic [RD_LAT-1:0] r_vld;
    logic [WIDTH-1:0]  r_dat [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign o_valid = r_vld[RD_LAT-1];
    assign o_data  = r_dat[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : sram_dp_be
// Description : Simple dual-port SRAM (one write, one read port per cycle)
//               with byte-lane write enables, write-first forwarding,
//               out-of-range protection, RD_LAT-cycle read pipeline and an
//               optional post-reset clear sequencer.
// Ports       : clk, rst (sync, active-high), bus (sram_dp_be_if.slave):
//               busy, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
//               rd_data, rd_valid
// Revision    : 1.0 - initial release
// ============================================================================
module sram_dp_be
    import cpu_mem_pkg::*;
#(
    parameter int ADDR           = 8,
    parameter int WIDTH          = 32,
    parameter int LENGTH         = 256,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    sram_dp_be_if.slave  bus
);
    localparam int              c_lanes = WIDTH / c_byte_w;
    localparam logic [ADDR-1:0] c_last  = ADDR'(LENGTH - 1);
    // One extra bit so LENGTH == 2**ADDR is representable
    localparam logic [ADDR:0]   c_len   = (ADDR+1)'(LENGTH);

    state_t           r_state;
    logic             r_busy;
    logic [ADDR-1:0]  r_cnt;
    logic [WIDTH-1:0] r_mem [LENGTH];

    logic             w_wr_in;
    logic             w_rd_in;
    logic             w_ready;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_fwd;
    logic [WIDTH-1:0] w_wr_old;
    logic [WIDTH-1:0] w_rd_raw;
    logic [WIDTH-1:0] w_wr_word;
    logic [WIDTH-1:0] w_rd_word;

    assign w_wr_in  = ({1'b0, bus.wr_addr} < c_len);
    assign w_rd_in  = ({1'b0, bus.rd_addr} < c_len);
    assign w_ready  = (r_state == ST_READY) && !rst;
    assign w_wr_ok  = w_ready && bus.wr_en && w_wr_in;
    assign w_rd_ok  = w_ready && bus.rd_en;
    assign w_fwd    = w_wr_ok && w_rd_in && (bus.wr_addr == bus.rd_addr);

    // Out-of-range reads return zero rather than touching the array
    assign w_wr_old = w_wr_in ? r_mem[bus.wr_addr] : '0;
    assign w_rd_raw = w_rd_in ? r_mem[bus.rd_addr] : '0;

    // Byte merge for the stored word and, when addresses collide, for the
    // word being read this cycle (write-first)
    always_comb begin
        w_wr_word = w_wr_old;
        w_rd_word = w_rd_raw;
        for (int i = 0; i < c_lanes; i++) begin
            w_wr_word[i*c_byte_w +: c_byte_w] =
                merge_byte(w_wr_old[i*c_byte_w +: c_byte_w],
                           bus.wr_data[i*c_byte_w +: c_byte_w], bus.wr_be[i]);
            if (w_fwd) begin
                w_rd_word[i*c_byte_w +: c_byte_w] =
                    merge_byte(w_rd_raw[i*c_byte_w +: c_byte_w],
                               bus.wr_data[i*c_byte_w +: c_byte_w], bus.wr_be[i]);
            end
        end
    end

    // Clear sequencer; busy is registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_busy  <= (CLEAR_ON_RESET != 0);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == c_last) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: no reset on the array itself, contents come from the clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_ok) begin
                r_mem[bus.wr_addr] <= w_wr_word;
            end
        end
    end

    sram_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd_ok),
        .i_data  (w_rd_word),
        .o_valid (bus.rd_valid),
        .o_data  (bus.rd_data)
    );

    assign bus.busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_dp_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_dp_be
// Description : Self-checking bench for sram_dp_be. Instance A uses
//               LENGTH=256, RD_LAT=2; instance B uses LENGTH=200, RD_LAT=1.
//               Expected read results are queued when a read is issued and
//               compared (data and arrival cycle) when rd_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_dp_be;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_dp_be_if #(.ADDR(8), .WIDTH(32)) ia ();
    sram_dp_be_if #(.ADDR(8), .WIDTH(32)) ib ();

    sram_dp_be #(
        .ADDR(8), .WIDTH(32), .LENGTH(256), .RD_LAT(2), .CLEAR_ON_RESET(1)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    sram_dp_be #(
        .ADDR(8), .WIDTH(32), .LENGTH(200), .RD_LAT(1), .CLEAR_ON_RESET(1)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop and compare whenever a read result appears
    always @(negedge clk) begin
        if (ia.rd_valid === 1'b1) begin
            checks++;
            assert (qa.size() > 0) else begin
                errors++;
                $error("FAIL a_unexpected_valid observed rd_valid=1 at cycle %0d expected 0", cyc);
            end
            if (qa.size() > 0) begin
                exp_t e;
                e = qa.pop_front();
                chk("a_rd_data", ia.rd_data, e.data);
                chk("a_rd_cycle", cyc, e.due);
            end
        end
        if (ib.rd_valid === 1'b1) begin
            checks++;
            assert (qb.size() > 0) else begin
                errors++;
                $error("FAIL b_unexpected_valid observed rd_valid=1 at cycle %0d expected 0", cyc);
            end
            if (qb.size() > 0) begin
                exp_t e;
                e = qb.pop_front();
                chk("b_rd_data", ib.rd_data, e.data);
                chk("b_rd_cycle", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        ia.wr_en = 1'b1; ia.wr_addr = a; ia.wr_data = d; ia.wr_be = be;
        tick();
        ia.wr_en = 1'b0;
    endtask

    task automatic rd_a(input logic [7:0] a, input logic [31:0] exp);
        ia.rd_en = 1'b1; ia.rd_addr = a;
        qa.push_back('{exp, cyc + 2});
        tick();
        ia.rd_en = 1'b0;
    endtask

    task automatic wr_b(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        ib.wr_en = 1'b1; ib.wr_addr = a; ib.wr_data = d; ib.wr_be = be;
        tick();
        ib.wr_en = 1'b0;
    endtask

    task automatic rd_b(input logic [7:0] a, input logic [31:0] exp);
        ib.rd_en = 1'b1; ib.rd_addr = a;
        qb.push_back('{exp, cyc + 1});
        tick();
        ib.rd_en = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() > 0 || qb.size() > 0) && t < 20) begin
            tick();
            t++;
        end
        chk("outstanding_reads", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    task automatic count_busy(output int na, output int nb);
        na = 0;
        nb = 0;
        while (ia.busy === 1'b1 && na < 1000) begin
            na++;
            if (ib.busy === 1'b1) nb++;
            tick();
        end
    endtask

    initial begin
        int na;
        int nb;
        ia.wr_en = 0; ia.wr_addr = 0; ia.wr_be = 0; ia.wr_data = 0;
        ia.rd_en = 0; ia.rd_addr = 0;
        ib.wr_en = 0; ib.wr_addr = 0; ib.wr_be = 0; ib.wr_data = 0;
        ib.rd_en = 0; ib.rd_addr = 0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy_a", 32'(ia.busy), 32'd1);
        chk("rst_valid_a", 32'(ia.rd_valid), 32'd0);
        chk("rst_data_a", ia.rd_data, 32'd0);
        chk("rst_busy_b", 32'(ib.busy), 32'd1);
        rst = 1'b0;

        // Requests during the clear must be ignored
        ia.wr_en = 1'b1; ia.wr_addr = 8'd17; ia.wr_data = 32'hFFFF_FFFF; ia.wr_be = 4'hF;
        ia.rd_en = 1'b1; ia.rd_addr = 8'd0;
        count_busy(na, nb);
        ia.wr_en = 1'b0;
        ia.rd_en = 1'b0;
        chk("busy_len_a", 32'(na), 32'd256);
        chk("busy_len_b", 32'(nb), 32'd200);
        chk("busy_end_b", 32'(ib.busy), 32'd0);

        // Cleared contents
        rd_a(8'd0, 32'h0);
        rd_a(8'd17, 32'h0);
        rd_a(8'd255, 32'h0);
        drain();

        // Byte enables
        wr_a(8'd5, 32'hAABB_CCDD, 4'b1111);
        wr_a(8'd5, 32'h1122_3344, 4'b0101);
        rd_a(8'd5, 32'hAA22_CC44);
        wr_a(8'd5, 32'h9999_9999, 4'b0000);
        rd_a(8'd5, 32'hAA22_CC44);

        // Back-to-back reads with RD_LAT=2
        wr_a(8'd1, 32'h10, 4'hF);
        wr_a(8'd2, 32'h20, 4'hF);
        wr_a(8'd3, 32'h30, 4'hF);
        wr_a(8'd4, 32'h40, 4'hF);
        rd_a(8'd1, 32'h10);
        rd_a(8'd2, 32'h20);
        rd_a(8'd3, 32'h30);
        rd_a(8'd4, 32'h40);
        drain();

        // Write in cycle N visible to a read in cycle N+1
        wr_a(8'd6, 32'hCAFE_F00D, 4'hF);
        rd_a(8'd6, 32'hCAFE_F00D);

        // Same-cycle write/read to one address: write-first
        wr_a(8'd9, 32'h1234_5678, 4'hF);
        ia.wr_en = 1'b1; ia.wr_addr = 8'd9; ia.wr_data = 32'hFFFF_FFFF; ia.wr_be = 4'b1000;
        rd_a(8'd9, 32'hFF34_5678);
        ia.wr_en = 1'b0;
        rd_a(8'd9, 32'hFF34_5678);
        drain();

        // Out-of-range on B (LENGTH=200)
        wr_b(8'd250, 32'hDEAD_BEEF, 4'hF);
        rd_b(8'd250, 32'h0);
        rd_b(8'd50, 32'h0);
        wr_b(8'd199, 32'h5A5A_5A5A, 4'hF);
        rd_b(8'd199, 32'h5A5A_5A5A);
        drain();

        // Reset one cycle after a read is accepted: that result never appears
        ia.rd_en = 1'b1; ia.rd_addr = 8'd5;
        tick();
        ia.rd_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy_a", 32'(ia.busy), 32'd1);
        chk("midrst_valid_a", 32'(ia.rd_valid), 32'd0);
        count_busy(na, nb);
        chk("reclear_len_a", 32'(na), 32'd256);
        rd_a(8'd5, 32'h0);
        rd_a(8'd9, 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- Parametrised successor of the single-port SRAM.
- Simple dual-port memory: one write port and one independent read port, usable in the same cycle.
- Adds byte-lane write enables, a configurable read pipeline with a valid flag, and write-first forwarding.
- Adds a reset-time clear sequencer so contents are deterministic without a preload file.
- Sits between the CPU datapath / load-store unit and on-chip data storage.

Parameters:
ADDR, 8, address width in bits
WIDTH, 32, data width in bits; must be a multiple of 8
LENGTH, 256, number of words; 1 <= LENGTH <= 2**ADDR
RD_LAT, 1, read latency in cycles; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
busy  output  1  high while the clear sequence runs; all requests are ignored while high
wr_en  input  1  write request
wr_addr  input  ADDR  write word address
wr_be  input  WIDTH/8  byte enables; bit i enables data bits [8i+7:8i]
wr_data  input  WIDTH  write data
rd_en  input  1  read request
rd_addr  input  ADDR  read word address
rd_data  output  WIDTH  read data; meaningful only when rd_valid=1
rd_valid  output  1  rd_data carries the result of a read issued RD_LAT cycles earlier

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: busy=CLEAR_ON_RESET, rd_valid=0, rd_data=0, read pipeline valids=0, clear counter=0.
- FSM has two states, CLEAR and READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
- CLEAR state:
  - Each cycle writes 0 to mem[cnt], then cnt increments.
  - When cnt==LENGTH-1 is written, the next state is READY and busy drops.
  - busy is therefore high for exactly LENGTH cycles after the rst cycle.
  - wr_en and rd_en are ignored: no write, no rd_valid.
- READY, write:
  - If wr_en=1 and wr_addr<LENGTH, byte i of mem[wr_addr] takes wr_data byte i for each wr_be[i]=1.
  - Other bytes are unchanged.
  - wr_be=0 means no change.
- READY, read:
  - If rd_en=1, the read is accepted.
  - rd_valid=1 and rd_data=result exactly RD_LAT cycles later.
  - For RD_LAT=2, an extra output register stage is added.
- Throughput: one read and one write per cycle, back-to-back, with no bubbles.
- Same-cycle read and write to the same in-range address (write-first):
  - The read returns the old word with the enabled bytes replaced by wr_data.
- A write in cycle N is visible to any read issued in cycle N+1 or later.
- Out-of-range addresses (>=LENGTH):
  - A write is dropped.
  - A read completes normally with rd_valid=1 and rd_data=0.
- When rd_valid=0, rd_data holds its last value; verification checks rd_data only when rd_valid=1.
- Reset mid-operation:
  - In-flight reads are discarded; rd_valid=0 the next cycle.
  - The clear restarts from address 0.
  - rst asserted during CLEAR restarts the count.
- No preload file; initial contents are undefined when CLEAR_ON_RESET=0.

Decomposition:
- Shared package (cpu_mem_pkg):
  - FSM state encoding (ST_CLEAR, ST_READY).
  - Byte lane constant (8).
  - Helper function for byte-merge of old word, new data and enables.
- One natural sub-module, sram_rd_pipe: the RD_LAT-deep data/valid shift register with synchronous reset.
- Storage array, clear sequencer and forwarding logic stay in the top module.

Test Plan:
- Clear: pulse rst with CLEAR_ON_RESET=1, LENGTH=256 -> busy high for exactly 256 cycles. Reading addr 0, 17 and 255 afterwards -> rd_data=0x00000000 with rd_valid=1. A wr_en during busy -> no effect.
- Byte enables: write 0xAABBCCDD with be=1111 at addr 5, then 0x11223344 with be=0101 -> read of addr 5 returns 0xAA22CC44.
- Latency: RD_LAT=2; reads issued on 4 consecutive cycles at addrs 1-4 preloaded with 0x10-0x40 -> rd_valid high on 4 consecutive cycles starting 2 cycles after the first rd_en, data 0x10, 0x20, 0x30, 0x40 in order.
- Forwarding: addr 9 holds 0x12345678; same-cycle write 0xFFFFFFFF be=1000 and read of addr 9 -> rd_data=0xFF345678.
- Out-of-range: LENGTH=200, ADDR=8; write 0xDEADBEEF to addr 250 then read addr 250 -> rd_data=0, rd_valid=1. Addr 250-200=50 is unchanged.
- Reset mid-read: RD_LAT=2; issue a read, then assert rst on the next cycle -> rd_valid never asserts for that read, busy rises and the clear restarts at address 0.
